zhang_cnn_div_seq_16s_9ns_16: RTL and testbench

Multi-cycle sequential divider that inverts the 9-bit unsigned × 16-bit signed scaling multiply in the quantized CNN datapath. It takes a 16-bit signed value and a 9-bit unsigned scale, and returns a 16-bit signed quotient and a signed remainder. Division truncates toward zero, which is C semantics. It sits on the dequantize/rescale path between accumulator output and the next layer's quantizer, and has valid/ready handshakes on both sides.

---
 rtl/zhang_cnn_div_seq_16s_9ns_16_pkg.sv | 10 +
 rtl/zhang_cnn_div_seq_16s_9ns_16_if.sv | 10 +
 rtl/zhang_cnn_div_seq_16s_9ns_16_step.sv | 15 +
 rtl/zhang_cnn_div_seq_16s_9ns_16.sv | 77 +++++++
 tb/tb_zhang_cnn_div_seq_16s_9ns_16.sv | 134 +++++++++++++
 5 files changed

// File: rtl/zhang_cnn_div_seq_16s_9ns_16_pkg.sv
// zhang_cnn_div_pkg: shared widths, FSM states and saturation constants for the sequential divider
package zhang_cnn_div_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W = 9;
  localparam int REM_W = DIVISOR_W + 1;
  localparam int CNT_W = 4;
  localparam logic [DIVIDEND_W-1:0] QMAX = 16'h7FFF;
  localparam logic [DIVIDEND_W-1:0] QMIN = 16'h8000;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/zhang_cnn_div_seq_16s_9ns_16_if.sv
// zhang_cnn_div_seq_16s_9ns_16_if: operand/result handshake bundle of the divider
interface zhang_cnn_div_seq_16s_9ns_16_if;
  import zhang_cnn_div_pkg::*;
  logic in_vld, in_rdy, out_vld, out_rdy, div_by_zero;
  logic [DIVIDEND_W-1:0] din0, quot;
  logic [DIVISOR_W-1:0] din1;
  logic [REM_W-1:0] rem;
  modport master (output in_vld, din0, din1, out_rdy, input in_rdy, out_vld, quot, rem, div_by_zero);
  modport slave (input in_vld, din0, din1, out_rdy, output in_rdy, out_vld, quot, rem, div_by_zero);
endinterface

// File: rtl/zhang_cnn_div_seq_16s_9ns_16_step.sv
// zhang_cnn_div_step: one combinational restoring-division step
module zhang_cnn_div_step
  import zhang_cnn_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] dvs_i,
  output logic [REM_W-1:0]     rem_o,
  output logic                 q_o
);
  logic [REM_W-1:0] sh;
  assign sh = {rem_i, bit_i};
  assign q_o = sh >= {1'b0, dvs_i};
  assign rem_o = q_o ? sh - {1'b0, dvs_i} : sh;
endmodule

// File: rtl/zhang_cnn_div_seq_16s_9ns_16.sv
// zhang_cnn_div_seq_16s_9ns_16: 16-step sequential signed/unsigned divider, C truncating semantics
module zhang_cnn_div_seq_16s_9ns_16
  import zhang_cnn_div_pkg::*;
(
  input logic ap_clk,
  input logic ap_rst_n,
  zhang_cnn_div_seq_16s_9ns_16_if.slave io
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d, zero_q, zero_d, dbz_q, dbz_d, q_bit, accept, fix;
  logic [DIVIDEND_W-1:0] a_q, a_d, quot_q, quot_d;
  logic [DIVISOR_W-1:0] dvs_q, dvs_d;
  logic [REM_W-1:0] r_q, r_d, rem_q, rem_d, r_nxt;
  assign accept = state_q == IDLE && io.in_vld;
  assign fix = state_q == FIX;
  // a_q shifts dividend bits out at the top and quotient bits in at the bottom
  zhang_cnn_div_step u_step (
    .rem_i(r_q[DIVISOR_W-1:0]),
    .bit_i(a_q[DIVIDEND_W-1]),
    .dvs_i(dvs_q),
    .rem_o(r_nxt),
    .q_o  (q_bit)
  );
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      a_q     <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      a_q     <= a_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (io.in_vld) state_d = CALC;
      CALC: if (cnt_q == 4'd15) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (io.out_rdy) state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = state_q == CALC ? cnt_q + 4'd1 : '0;
    sign_d = accept ? io.din0[DIVIDEND_W-1] : sign_q;
    a_d    = accept ? (io.din0[DIVIDEND_W-1] ? -io.din0 : io.din0)
           : state_q == CALC ? {a_q[DIVIDEND_W-2:0], q_bit} : a_q;
    dvs_d  = accept ? io.din1 : dvs_q;
    zero_d = accept ? io.din1 == '0 : zero_q;
    r_d    = accept ? '0 : state_q == CALC ? r_nxt : r_q;
    quot_d = !fix ? quot_q : zero_q ? (sign_q ? QMIN : QMAX) : sign_q ? -a_q : a_q;
    rem_d  = !fix ? rem_q : zero_q ? '0 : sign_q ? -r_q : r_q;
    dbz_d  = fix ? zero_q : dbz_q;
  end
  always_comb begin
    io.in_rdy      = state_q == IDLE;
    io.out_vld     = state_q == DONE;
    io.quot        = quot_q;
    io.rem         = rem_q;
    io.div_by_zero = dbz_q;
  end
endmodule

// File: tb/tb_zhang_cnn_div_seq_16s_9ns_16.sv
// tb_zhang_cnn_div_seq_16s_9ns_16: directed corners plus random sweep against C-style division model
module tb_zhang_cnn_div_seq_16s_9ns_16;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  zhang_cnn_div_seq_16s_9ns_16_if io ();
  zhang_cnn_div_seq_16s_9ns_16 dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .io(io));
  always #5 ap_clk = ~ap_clk;
  task automatic check(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = a < 0 ? -32768 : 32767;
      r = 0;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction
  task automatic run(input int a, input int b, input int gap_in, input int gap_out, input bit chk_hold);
    int q, r, z, lat;
    model(a, b, q, r, z);
    io.in_vld = 1'b0;
    repeat (gap_in) begin
      @(posedge ap_clk);
      #1;
    end
    check("in_rdy_idle", int'(io.in_rdy), 1);
    io.in_vld = 1'b1;
    io.din0 = 16'(a);
    io.din1 = 9'(b);
    @(posedge ap_clk);
    #1;
    lat = 0;
    while (!io.out_vld && lat < 40) begin
      io.in_vld = 1'($urandom_range(0, 1));
      io.din0 = 16'($urandom);
      io.din1 = 9'($urandom);
      @(posedge ap_clk);
      #1;
      lat++;
    end
    check("latency", lat, 17);
    check("quot", int'($signed(io.quot)), q);
    check("rem", int'($signed(io.rem)), r);
    check("div_by_zero", int'(io.div_by_zero), z);
    io.out_rdy = 1'b0;
    for (int i = 0; i < gap_out; i++) begin
      io.in_vld = 1'b1;
      io.din0 = 16'($urandom);
      io.din1 = 9'($urandom);
      @(posedge ap_clk);
      #1;
      if (chk_hold) begin
        check("hold_out_vld", int'(io.out_vld), 1);
        check("hold_in_rdy", int'(io.in_rdy), 0);
        check("hold_quot", int'($signed(io.quot)), q);
        check("hold_rem", int'($signed(io.rem)), r);
      end
    end
    io.out_rdy = 1'b1;
    @(posedge ap_clk);
    #1;
    io.out_rdy = 1'b0;
    io.in_vld = 1'b0;
    check("out_vld_drop", int'(io.out_vld), 0);
    check("in_rdy_back", int'(io.in_rdy), 1);
  endtask
  initial begin
    int a, b;
    logic [15:0] ra;
    io.in_vld = 1'b0;
    io.out_rdy = 1'b0;
    io.din0 = '0;
    io.din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_in_rdy", int'(io.in_rdy), 1);
    check("rst_out_vld", int'(io.out_vld), 0);
    check("rst_quot", int'(io.quot), 0);
    check("rst_rem", int'(io.rem), 0);
    check("rst_dbz", int'(io.div_by_zero), 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    run(100, 7, 0, 0, 0);
    run(-100, 7, 1, 0, 0);
    run(32767, 511, 0, 2, 0);
    run(-32768, 1, 0, 0, 0);
    run(0, 5, 0, 0, 0);
    run(1234, 0, 0, 20, 1);
    run(-5, 0, 0, 0, 0);
    io.in_vld = 1'b1;
    io.din0 = 16'd100;
    io.din1 = 9'd7;
    @(posedge ap_clk);
    #1;
    io.in_vld = 1'b0;
    repeat (8) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_in_rdy", int'(io.in_rdy), 1);
    check("midrst_out_vld", int'(io.out_vld), 0);
    check("midrst_quot", int'(io.quot), 0);
    check("midrst_rem", int'(io.rem), 0);
    check("midrst_dbz", int'(io.div_by_zero), 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    run(100, 7, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        default: ;
      endcase
      a = int'($signed(ra));
      b = $urandom_range(0, 15) == 0 ? 0 : $urandom_range(0, 1) == 0 ? $urandom_range(1, 8) : $urandom_range(0, 511);
      run(a, b, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
